// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter for the byte-wide Memory port with a per-transaction watchdog
// Ports: clk/reset (sync, active-high); a_* and b_* requester ports (addr, wdata, read, write in;
// rdata, ready out); m_* Memory side (addr, wdata, read, write out; rdata, ready in);
// timeout_err pulses when the watchdog forces completion; grant_b flags port B ownership.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    input  logic              a_read,
    input  logic              a_write,
    output logic [7:0]        a_rdata,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    input  logic              b_read,
    input  logic              b_write,
    output logic [7:0]        b_rdata,
    output logic              b_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    output logic              m_read,
    output logic              m_write,
    input  logic              m_ready,
    output logic              timeout_err,
    output logic              grant_b
);
    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, RELEASE} state_t;
    state_t state, state_nx;
    logic last_b;
    logic [CNT_W-1:0] cnt;
    logic a_req, b_req, go_a, go_b, busy, tmo, done;
    always_comb begin
        a_req    = a_read | a_write;
        b_req    = b_read | b_write;
        go_a     = state == IDLE && a_req && (!b_req || last_b);
        go_b     = state == IDLE && b_req && !go_a;
        busy     = state == BUSY_A || state == BUSY_B;
        // m_ready on the last allowed cycle wins over the watchdog
        tmo      = busy && !m_ready && TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        done     = busy && (m_ready || tmo);
        state_nx = go_a ? BUSY_A : go_b ? BUSY_B : done ? RELEASE : state == RELEASE ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b      <= 1'b1;
            cnt         <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= busy ? cnt + 1'b1 : '0;
            if (go_a || go_b) begin
                last_b  <= go_b;
                m_addr  <= go_a ? a_addr : b_addr;
                m_wdata <= go_a ? a_wdata : b_wdata;
                m_write <= go_a ? a_write : b_write;
                m_read  <= go_a ? a_read && !a_write : b_read && !b_write;
            end
            if (done) begin
                m_read      <= 1'b0;
                m_write     <= 1'b0;
                timeout_err <= tmo;
                if (state == BUSY_A) begin
                    a_ready <= 1'b1;
                    a_rdata <= tmo ? 8'hFF : m_rdata;
                end else begin
                    b_ready <= 1'b1;
                    b_rdata <= tmo ? 8'hFF : m_rdata;
                end
            end
        end
    end
    assign grant_b = state == BUSY_B || (state == RELEASE && last_b);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int TMO = 8;
    logic clk = 0, reset = 1;
    logic [31:0] a_addr = 0, b_addr = 0, m_addr;
    logic [7:0] a_wdata = 0, b_wdata = 0, m_rdata = 0, a_rdata, b_rdata, m_wdata;
    logic a_read = 0, a_write = 0, b_read = 0, b_write = 0, m_ready = 0;
    logic a_ready, b_ready, m_read, m_write, timeout_err, grant_b;
    logic [31:0] z_a_addr = 32'h40, z_b_addr = 0, z_m_addr;
    logic [7:0] z_a_wdata = 0, z_b_wdata = 0, z_m_rdata = 0, z_a_rdata, z_b_rdata, z_m_wdata;
    logic z_a_read = 1, z_a_write = 0, z_b_read = 0, z_b_write = 0, z_m_ready = 0;
    logic z_a_ready, z_b_ready, z_m_read, z_m_write, z_timeout_err, z_grant_b;
    int checks = 0, errors = 0;
    logic last_b = 1;
    logic [7:0] exp_rd [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_read(a_read), .a_write(a_write),
        .a_rdata(a_rdata), .a_ready(a_ready),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_read(b_read), .b_write(b_write),
        .b_rdata(b_rdata), .b_ready(b_ready),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_read(m_read),
        .m_write(m_write), .m_ready(m_ready), .timeout_err(timeout_err), .grant_b(grant_b)
    );

    mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(0), .CNT_W(11)) u0 (
        .clk(clk), .reset(reset),
        .a_addr(z_a_addr), .a_wdata(z_a_wdata), .a_read(z_a_read), .a_write(z_a_write),
        .a_rdata(z_a_rdata), .a_ready(z_a_ready),
        .b_addr(z_b_addr), .b_wdata(z_b_wdata), .b_read(z_b_read), .b_write(z_b_write),
        .b_rdata(z_b_rdata), .b_ready(z_b_ready),
        .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_rdata(z_m_rdata), .m_read(z_m_read),
        .m_write(z_m_write), .m_ready(z_m_ready), .timeout_err(z_timeout_err), .grant_b(z_grant_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic rd, input logic wr, input logic [31:0] addr, input logic [7:0] wd);
        if (p == 0) begin
            a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
        end else begin
            b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
        end
    endtask

    // Round-robin rule: a lone requester wins; on a tie the port not granted last time wins.
    function automatic int win(input logic a, input logic b);
        return (a && b) ? (last_b ? 0 : 1) : (a ? 0 : 1);
    endfunction

    // Called at a negedge in IDLE with requests already driven. Memory answers lat cycles into
    // BUSY; at most TMO busy cycles are allowed before the watchdog completes with 0xFF.
    task automatic txn(input int p, input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                       input int lat, input logic [7:0] data);
        int n;
        logic to;
        to = lat >= TMO;
        n = to ? TMO - 1 : lat;
        step();
        chk("m_read", m_read, !wr);
        chk("m_write", m_write, wr);
        chk("m_addr", m_addr, addr);
        chk("m_wdata", m_wdata, wd);
        chk("grant_b_busy", grant_b, p);
        for (int i = 0; i <= n; i++) begin
            m_ready = (i == lat);
            m_rdata = (i == lat) ? data : 8'($urandom);
            if (i > 0) begin
                chk("strobe_held", m_read | m_write, 1);
                chk("early_ready", {a_ready, b_ready, timeout_err}, 0);
            end
            step();
        end
        m_ready = 0;
        last_b = (p == 1);
        exp_rd[p] = to ? 8'hFF : data;
        chk("a_ready", a_ready, p == 0);
        chk("b_ready", b_ready, p == 1);
        chk("a_rdata", a_rdata, exp_rd[0]);
        chk("b_rdata", b_rdata, exp_rd[1]);
        chk("timeout_err", timeout_err, to);
        chk("release_strobe", {m_read, m_write}, 0);
        chk("grant_b_release", grant_b, p);
        step();
        chk("idle_ready", {a_ready, b_ready, timeout_err}, 0);
        chk("idle_strobe", {m_read, m_write}, 0);
        chk("grant_b_idle", grant_b, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
        last_b = 1;
        exp_rd = '{8'h00, 8'h00};
        chk("reset_outs", {a_rdata, b_rdata, m_wdata, a_ready, b_ready, m_read, m_write, timeout_err, grant_b}, 0);
        chk("reset_addr", m_addr, 0);
    endtask

    initial begin
        int p, bad, la, lb, opa, opb;
        logic [31:0] aa, ba;
        logic [7:0] aw, bw;
        @(negedge clk);
        do_reset();

        drive(0, 1, 0, 32'h100, 8'h00);
        txn(0, 0, 32'h100, 8'h00, 2, 8'h5A);
        drive(0, 0, 0, 0, 0);

        for (int k = 0; k < 2; k++) begin
            m_ready = 1;
            m_rdata = 8'hC3;
            step();
            m_ready = 0;
            chk("stray_ready", {a_ready, b_ready, timeout_err}, 0);
            chk("stray_strobe", {m_read, m_write, grant_b}, 0);
            chk("stray_rdata", a_rdata, 8'h5A);
        end

        do_reset();
        drive(0, 1, 0, 32'h1000, 8'h00);
        drive(1, 1, 0, 32'h2000, 8'h00);
        for (int k = 0; k < 4; k++) begin
            p = win(1, 1);
            txn(p, 0, p ? 32'h2000 : 32'h1000, 8'h00, k, 8'(8'h10 + k));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        drive(1, 1, 1, 32'h20, 8'h33);
        txn(1, 1, 32'h20, 8'h33, 1, 8'h77);
        drive(1, 0, 0, 0, 0);

        drive(0, 1, 0, 32'h300, 8'h00);
        txn(0, 0, 32'h300, 8'h00, 1000, 8'h00);
        drive(0, 0, 0, 0, 0);

        drive(1, 1, 0, 32'h44, 8'h00);
        step();
        chk("busy_b_grant", grant_b, 1);
        chk("busy_b_read", m_read, 1);
        reset = 1;
        step();
        reset = 0;
        last_b = 1;
        exp_rd = '{8'h00, 8'h00};
        chk("midreset_outs", {a_rdata, b_rdata, m_wdata, a_ready, b_ready, m_read, m_write, timeout_err, grant_b}, 0);
        chk("midreset_addr", m_addr, 0);
        drive(0, 1, 0, 32'h55, 8'h00);
        p = win(1, 1);
        txn(p, 0, p ? 32'h44 : 32'h55, 8'h00, 0, 8'hA1);
        p = win(1, 1);
        txn(p, 0, p ? 32'h44 : 32'h55, 8'h00, 3, 8'hB2);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            la = $urandom_range(0, 1);
            lb = $urandom_range(0, 1);
            opa = la ? $urandom_range(1, 3) : 0;
            opb = lb ? $urandom_range(1, 3) : 0;
            aa = $urandom;
            ba = $urandom;
            aw = 8'($urandom);
            bw = 8'($urandom);
            drive(0, opa[0], opa[1], aa, aw);
            drive(1, opb[0], opb[1], ba, bw);
            if (la == 0 && lb == 0) begin
                m_ready = 1'($urandom);
                step();
                m_ready = 0;
                chk("rand_idle_ready", {a_ready, b_ready, timeout_err}, 0);
                chk("rand_idle_strobe", {m_read, m_write, grant_b}, 0);
            end else begin
                p = win(la != 0, lb != 0);
                txn(p, p ? opb[1] : opa[1], p ? ba : aa, p ? bw : aw, $urandom_range(0, 10), 8'($urandom));
            end
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        bad = 0;
        repeat (5000) begin
            step();
            if (z_timeout_err || z_a_ready || !z_m_read) bad++;
        end
        chk("no_watchdog_when_disabled", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
